// File: rtl/four_port_switch.sv
// Four-port single-beat packet switch with per-input FIFOs, per-output
// round-robin arbitration and parallel multicast copy from a FIFO head.
// Optional feature macro: DROP_CNT_EN adds drop_cnt (per-port dropped-copy counters).
module four_port_switch #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [3:0]                           valid_in,
  input  logic [7:0]                           source_in,
  input  logic [15:0]                          target_in,
  input  logic [4*DATA_W-1:0]                  data_in,
  output logic [3:0]                           valid_out,
  output logic [7:0]                           source_out,
  output logic [15:0]                          target_out,
  output logic [4*DATA_W-1:0]                  data_out,
  output logic [3:0]                           fifo_full,
  output logic [3:0]                           fifo_empty,
  output logic [4*($clog2(FIFO_DEPTH)+1)-1:0]  fifo_count
`ifdef DROP_CNT_EN
  ,
  output logic [63:0]                          drop_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 6 + DATA_W;  // entry = {src[1:0], tgt[3:0], data}

  logic [4*EW-1:0] head_all;  // head entry of each input FIFO
  logic [15:0]     pend_all;  // [4p+o]: head of FIFO p still owes a copy to output o
  logic [15:0]     gnt_all;   // [4o+p]: output o granted to input p this cycle

  // ---------------------------------------------------------------- inputs
  for (genvar gi = 0; gi < 4; gi++) begin : g_port
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [3:0]    pend_q, pend_d, pend_left, win, tgt_in, next_tgt;
    logic          push, pop, empty, full;

    assign tgt_in    = target_in[4*gi +: 4];
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(FIFO_DEPTH));
    // Full is the registered state, so a slot freed by this cycle's pop is not reused.
    assign push      = valid_in[gi] && !full && (tgt_in != 4'b0000);
    assign win       = {gnt_all[12+gi], gnt_all[8+gi], gnt_all[4+gi], gnt_all[gi]};
    assign pend_left = pend_q & ~win;
    assign pop       = !empty && (pend_left == 4'b0000);
    assign next_tgt  = mem[rd_ptr_q + PW'(1)][DATA_W +: 4];

    // Pending mask: clear granted outputs; reload from the new head when one appears.
    always_comb begin
      pend_d = pend_left;
      if (pop) begin
        if (count_q > CW'(1))
          pend_d = next_tgt;
        else if (push)
          pend_d = tgt_in;
        else
          pend_d = 4'b0000;
      end else if (empty && push) begin
        pend_d = tgt_in;
      end
    end

    // FIFO pointers, explicit occupancy count and head pending mask.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        pend_q   <= 4'b0000;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        pend_q  <= pend_d;
      end
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
      if (push)
        mem[wr_ptr_q] <= {source_in[2*gi +: 2], tgt_in, data_in[DATA_W*gi +: DATA_W]};
    end

    assign head_all[EW*gi +: EW] = mem[rd_ptr_q];
    assign pend_all[4*gi +: 4]   = pend_q;
    assign fifo_full[gi]         = full;
    assign fifo_empty[gi]        = empty;
    assign fifo_count[CW*gi +: CW] = count_q;

`ifdef DROP_CNT_EN
    logic [15:0] drop_q;
    logic [16:0] drop_sum;
    assign drop_sum = {1'b0, drop_q} + 17'($countones(tgt_in));

    // Count lost copies of packets refused by a full FIFO, saturating.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        drop_q <= 16'h0000;
      else if (valid_in[gi] && full)
        drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    assign drop_cnt[16*gi +: 16] = drop_q;
`endif
  end

  // --------------------------------------------------------------- outputs
  for (genvar go = 0; go < 4; go++) begin : g_out
    logic [3:0]        req, gnt;
    logic [1:0]        rr_q, rr_d, sel, idx;
    logic              any;
    logic [EW-1:0]     head_sel;
    logic              vld_q;
    logic [1:0]        src_q;
    logic [3:0]        tgt_q;
    logic [DATA_W-1:0] dat_q;

    assign req = ~fifo_empty & {pend_all[12+go], pend_all[8+go], pend_all[4+go], pend_all[go]};

    // Round-robin search starting just after the last input served.
    always_comb begin
      any = 1'b0;
      sel = rr_q;
      idx = rr_q;
      for (int i = 1; i <= 4; i++) begin
        idx = rr_q + 2'(i);
        if (!any && req[idx]) begin
          any = 1'b1;
          sel = idx;
        end
      end
    end

    assign gnt      = any ? (4'b0001 << sel) : 4'b0000;
    assign rr_d     = any ? sel : rr_q;
    assign head_sel = head_all[EW*sel +: EW];
    assign gnt_all[4*go +: 4] = gnt;

    // Output register: load the granted head; fields hold when idle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        src_q <= 2'b00;
        tgt_q <= 4'b0000;
        dat_q <= '0;
        rr_q  <= 2'b00;
      end else begin
        vld_q <= any;
        rr_q  <= rr_d;
        if (any)
          {src_q, tgt_q, dat_q} <= head_sel;
      end
    end

    assign valid_out[go]                = vld_q;
    assign source_out[2*go +: 2]        = src_q;
    assign target_out[4*go +: 4]        = tgt_q;
    assign data_out[DATA_W*go +: DATA_W] = dat_q;
  end

endmodule

// File: tb/tb_four_port_switch.sv
// Bench for four_port_switch: directed vector table, round-robin and overflow
// sequences, random drain, asynchronous mid-traffic reset. A per-port model
// queue holds each accepted packet with its outstanding output mask.
module tb_four_port_switch;
  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  valid_in = '0;
  logic [7:0]  source_in = '0;
  logic [15:0] target_in = '0;
  logic [31:0] data_in = '0;
  logic [3:0]  valid_out;
  logic [7:0]  source_out;
  logic [15:0] target_out;
  logic [31:0] data_out;
  logic [3:0]  fifo_full;
  logic [3:0]  fifo_empty;
  logic [15:0] fifo_count;
`ifdef DROP_CNT_EN
  logic [63:0] drop_cnt;
`endif

  four_port_switch #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .source_in(source_in), .target_in(target_in), .data_in(data_in),
    .valid_out(valid_out), .source_out(source_out), .target_out(target_out), .data_out(data_out),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count)
`ifdef DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] src;
    logic [3:0] tgt;
    logic [7:0] data;
    logic [3:0] rem;
  } mpkt_t;

  typedef struct {
    int         port;
    logic [3:0] tgt;
    logic [7:0] data;
    logic [3:0] exp_valid;
  } vec_t;

  mpkt_t mq [4][$];
  int checks = 0;
  int errors = 0;
  int acc_copies = 0;
  int del_copies = 0;
  int drops_model [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present a packet on port p for the next edge; the model decides accept/drop.
  task automatic drive(input int p, input logic [3:0] tgt, input logic [7:0] data);
    mpkt_t e;
    valid_in[p] = 1'b1;
    source_in[2*p +: 2] = 2'(p);
    target_in[4*p +: 4] = tgt;
    data_in[8*p +: 8] = data;
    if (mq[p].size() == DEPTH) begin
      drops_model[p] += $countones(tgt);
    end else if (tgt != 4'b0000) begin
      e.src = 2'(p); e.tgt = tgt; e.data = data; e.rem = tgt;
      mq[p].push_back(e);
      acc_copies += $countones(tgt);
    end
  endtask

  // One clock: sample after the edge, score deliveries, check FIFO state, idle inputs.
  task automatic step();
    @(posedge clk);
    #1;
    for (int o = 0; o < 4; o++) begin
      if (valid_out[o]) begin
        int s;
        mpkt_t h;
        s = int'(source_out[2*o +: 2]);
        del_copies++;
        if (mq[s].size() == 0 || !mq[s][0].rem[o]) begin
          checks++;
          errors++;
          $display("FAIL unexpected_copy out=%0d actual src=%0d tgt=%0h data=%0h required=no copy",
                   o, s, target_out[4*o +: 4], data_out[8*o +: 8]);
        end else begin
          h = mq[s][0];
          chk($sformatf("copy_out%0d_src%0d", o, s), {target_out[4*o +: 4], data_out[8*o +: 8]},
              {h.tgt, h.data});
          h.rem[o] = 1'b0;
          mq[s][0] = h;
        end
      end
    end
    for (int p = 0; p < 4; p++)
      if (mq[p].size() > 0 && mq[p][0].rem == 4'b0000) void'(mq[p].pop_front());
    for (int p = 0; p < 4; p++) begin
      logic [3:0] n;
      n = 4'(mq[p].size());
      chk($sformatf("fifo_state_p%0d", p), {fifo_count[4*p +: 4], fifo_empty[p], fifo_full[p]},
          {n, (n == 4'd0), (n == 4'(DEPTH))});
    end
    valid_in = 4'b0000;
  endtask

  task automatic clear_model();
    for (int p = 0; p < 4; p++) mq[p].delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [5];
    int   rr_exp [4];
    int   full_seen;

    for (int p = 0; p < 4; p++) drops_model[p] = 0;
    vt[0] = '{0, 4'b0100, 8'hA5, 4'b0100};  // unicast
    vt[1] = '{1, 4'b1111, 8'h3C, 4'b1111};  // broadcast
    vt[2] = '{2, 4'b0000, 8'h77, 4'b0000};  // empty mask: discarded
    vt[3] = '{3, 4'b1010, 8'h5A, 4'b1010};  // multicast
    vt[4] = '{2, 4'b0001, 8'hC3, 4'b0001};  // unicast to out0
    rr_exp = '{1, 2, 3, 0};

    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_out", valid_out, 4'h0);
    chk("rst_fields", {source_out, target_out, data_out}, 56'h0);
    chk("rst_fifo", {fifo_count, fifo_empty, fifo_full}, {16'h0, 4'hF, 4'h0});
`ifdef DROP_CNT_EN
    chk("rst_drop_cnt", drop_cnt, 64'h0);
`endif
    rst = 1'b0;
    step();

    // Directed vectors: latency, fan-out, data hold when idle
    for (int i = 0; i < 5; i++) begin
      drive(vt[i].port, vt[i].tgt, vt[i].data);
      step();
      chk($sformatf("vec%0d_early", i), valid_out, 4'h0);
      step();
      chk($sformatf("vec%0d_valid", i), valid_out, vt[i].exp_valid);
      for (int o = 0; o < 4; o++)
        if (vt[i].exp_valid[o]) chk($sformatf("vec%0d_data_out%0d", i, o), data_out[8*o +: 8], vt[i].data);
      step();
      chk($sformatf("vec%0d_idle", i), valid_out, 4'h0);
      for (int o = 0; o < 4; o++)
        if (vt[i].exp_valid[o]) chk($sformatf("vec%0d_hold_out%0d", i, o), data_out[8*o +: 8], vt[i].data);
    end

    // Contention on output 0 straight after reset: order 1,2,3,0
    rst = 1'b1; #1 rst = 1'b0;
    clear_model();
    for (int p = 0; p < 4; p++) drive(p, 4'b0001, 8'(8'h10 + p));
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("rr_order_%0d", k), {valid_out[0], source_out[1:0]}, {1'b1, 2'(rr_exp[k])});
    end
    for (int i = 0; i < 20; i++) step();

    // Overflow: every port floods output 0, so all FIFOs fill and drop
    full_seen = 0;
    for (int c = 0; c < 24; c++) begin
      for (int p = 0; p < 4; p++) drive(p, (c < 12) ? 4'b0001 : 4'b1011, 8'(c * 4 + p));
      step();
      if (fifo_full[3]) full_seen = 1;
    end
    chk("overflow_full3_seen", 64'(full_seen), 64'd1);
`ifdef DROP_CNT_EN
    for (int p = 0; p < 4; p++)
      chk($sformatf("drop_cnt_p%0d", p), drop_cnt[16*p +: 16], 16'(drops_model[p]));
`endif
    for (int i = 0; i < 200; i++) step();
    chk("overflow_drained", fifo_empty, 4'hF);

    // Random traffic, then 1000 idle cycles: no copy lost
    acc_copies = 0;
    del_copies = 0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 4; p++)
        if ($urandom_range(0, 2) == 0) drive(p, 4'($urandom_range(0, 15)), 8'($urandom));
      step();
    end
    for (int i = 0; i < 1000; i++) step();
    chk("drain_empty", fifo_empty, 4'hF);
    chk("drain_copies", 64'(del_copies), 64'(acc_copies));

    // Asynchronous reset with FIFOs partly full
    for (int c = 0; c < 6; c++) begin
      for (int p = 0; p < 4; p++) drive(p, 4'($urandom_range(1, 15)), 8'($urandom));
      step();
    end
    rst = 1'b1;
    #1;
    chk("midrst_valid_out", valid_out, 4'h0);
    chk("midrst_fifo", {fifo_count, fifo_empty}, {16'h0, 4'hF});
    chk("midrst_fields", {source_out, target_out, data_out}, 56'h0);
`ifdef DROP_CNT_EN
    chk("midrst_drop_cnt", drop_cnt, 64'h0);
`endif
    #1 rst = 1'b0;
    clear_model();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
